// File: rtl/ycc_block_buffer.sv
// ycc_block_buffer: ping-pong 8x8 block buffer between the RGB-to-YCbCr converter and the DCT.
// Collects DATA_NUM samples per beat into one bank while the other bank drains one
// 8-sample vector per handshake, tagged with the block's component (Y/Cr/Cb).
// Build option: define YCC_BUF_TRANSPOSE_EN to drain columns instead of rows.

module ycc_block_buffer #(
  parameter int unsigned DATA_NUM = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [8*DATA_NUM-1:0] in_data,
  input  logic [1:0]            in_mode,
  output logic                  in_ready,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [63:0]           out_row,
  output logic [2:0]            out_idx,
  output logic [1:0]            out_mode,
  output logic                  out_last
);

  localparam int unsigned Beats    = 64 / DATA_NUM;
  localparam logic [5:0]  LastBeat = 6'(Beats - 1);

  typedef enum logic [1:0] {StEmpty, StFilling, StFull, StDraining} bank_st_e;

  bank_st_e    bank_st_q [2];
  bank_st_e    bank_st_d [2];
  logic [1:0]  tag_q [2];
  logic [1:0]  tag_d [2];
  logic [7:0]  mem_q [2][64];
  logic [7:0]  mem_d [2][64];
  logic        wr_bank_q, wr_bank_d;
  logic        rd_bank_q, rd_bank_d;
  logic [5:0]  wcnt_q, wcnt_d;
  logic        out_valid_q, out_valid_d;
  logic        out_last_q, out_last_d;
  logic [2:0]  out_idx_q, out_idx_d;
  logic [1:0]  out_mode_q, out_mode_d;
  logic [63:0] out_row_q, out_row_d;

  logic        wr_open, wr_fire;
  logic        rd_fire, rd_done, rd_free, rd_load, rd_sel;
  logic [2:0]  rd_idx;

  // in_ready depends only on the write bank's state.
  assign wr_open  = (bank_st_q[wr_bank_q] == StEmpty) || (bank_st_q[wr_bank_q] == StFilling);
  assign wr_fire  = in_valid && wr_open && !flush;
  assign in_ready = wr_open;

  // Storage and tag update for the accepted beat; the tag latches only on beat 0 with a legal mode.
  always_comb begin
    mem_d = mem_q;
    tag_d = tag_q;
    if (wr_fire) begin
      for (int unsigned i = 0; i < DATA_NUM; i++) begin
        mem_d[wr_bank_q][6'(int'(wcnt_q) * DATA_NUM + i)] = in_data[8*i +: 8];
      end
      if (wcnt_q == 6'd0 && in_mode != 2'b00) begin
        tag_d[wr_bank_q] = in_mode;
      end
    end
  end

  // Bank state machine, pointers and registered output control for both sides.
  always_comb begin
    bank_st_d   = bank_st_q;
    wcnt_d      = wcnt_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    out_mode_d  = out_mode_q;
    out_last_d  = out_last_q;
    rd_load     = 1'b0;
    rd_sel      = rd_bank_q;
    rd_idx      = out_idx_q;

    // Write side; flush wins over a same-cycle beat and never touches FULL/DRAINING banks.
    if (flush) begin
      if (wr_open) bank_st_d[wr_bank_q] = StEmpty;
      wcnt_d = 6'd0;
    end else if (wr_fire) begin
      if (wcnt_q == LastBeat) begin
        bank_st_d[wr_bank_q] = StFull;
        wcnt_d               = 6'd0;
        wr_bank_d            = ~wr_bank_q;
      end else begin
        bank_st_d[wr_bank_q] = StFilling;
        wcnt_d               = wcnt_q + 6'd1;
      end
    end

    // Read side; looks at post-write bank state so a just-completed block starts next cycle.
    rd_fire = out_valid_q && out_ready;
    rd_done = rd_fire && (out_idx_q == 3'd7);
    rd_free = !out_valid_q || rd_done;
    if (rd_done) begin
      bank_st_d[rd_bank_q] = StEmpty;
      rd_sel               = ~rd_bank_q;
      rd_bank_d            = ~rd_bank_q;
      out_valid_d          = 1'b0;
      out_last_d           = 1'b0;
      out_idx_d            = 3'd0;
    end
    if (rd_free && bank_st_d[rd_sel] == StFull) begin
      bank_st_d[rd_sel] = StDraining;
      out_valid_d       = 1'b1;
      out_idx_d         = 3'd0;
      out_last_d        = 1'b0;
      out_mode_d        = tag_d[rd_sel];
      rd_load           = 1'b1;
      rd_idx            = 3'd0;
    end else if (rd_fire && !rd_done) begin
      out_idx_d  = out_idx_q + 3'd1;
      out_last_d = (out_idx_q == 3'd6);
      rd_load    = 1'b1;
      rd_idx     = out_idx_q + 3'd1;
    end
  end

  // Gather the next output vector; reads mem_d so the final beat's samples are visible.
  always_comb begin
    out_row_d = out_row_q;
    if (rd_load) begin
      for (int unsigned k = 0; k < 8; k++) begin
`ifdef YCC_BUF_TRANSPOSE_EN
        out_row_d[8*k +: 8] = mem_d[rd_sel][{3'(k), rd_idx}];
`else
        out_row_d[8*k +: 8] = mem_d[rd_sel][{rd_idx, 3'(k)}];
`endif
      end
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_st_q   <= '{StEmpty, StEmpty};
      tag_q       <= '{2'b00, 2'b00};
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wcnt_q      <= 6'd0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_idx_q   <= 3'd0;
      out_mode_q  <= 2'b00;
      out_row_q   <= 64'd0;
    end else begin
      bank_st_q   <= bank_st_d;
      tag_q       <= tag_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wcnt_q      <= wcnt_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_idx_q   <= out_idx_d;
      out_mode_q  <= out_mode_d;
      out_row_q   <= out_row_d;
    end
  end

  // Sample storage; contents survive reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_idx   = out_idx_q;
  assign out_mode  = out_mode_q;
  assign out_row   = out_row_q;

endmodule
